reset_stall_controller: RTL and testbench
=========================================

RESET_STALL_CONTROLLER -- requirements
Module: reset_stall_controller

Interface
REQ-001 SHALL have parameter RESET_DOMAINS, default 4: number of independently resettable domains (>=1).
REQ-002 SHALL have parameter STALL_SOURCES, default 3: number of external level stall inputs (>=1).
REQ-003 SHALL have parameter FUNIT_COUNT, default 5: width of the functional-unit enable vector.
REQ-004 SHALL have parameter RESET_FUNIT, default 2: functional-unit index that owns the reset command.
REQ-005 SHALL have parameter RESET_OPCODE, default 4'hE: minor opcode of the reset command.
REQ-006 SHALL have parameter ACK_TIMEOUT, default 255: maximum clk_en cycles spent waiting for acks (>=1).
REQ-007 SHALL have ports: clk in 1, the single clock; async_rst_n in 1, asynchronous active-low reset; clk_en in 1, global clock enable.
REQ-008 SHALL have inputs: instruction_valid 1; minor_opcode_in 4; functional_unit_enable FUNIT_COUNT; reset_mask_in RESET_DOMAINS, domains selected by the command.
REQ-009 SHALL have inputs: reset_ack_in RESET_DOMAINS, per-domain completion; branch_stall_in 1; stall_sources_in STALL_SOURCES; halt_req_in 1, level; resume_in 1, pulse.
REQ-010 SHALL have outputs: reset_req_out RESET_DOMAINS, one-cycle request pulse; reset_busy 1; reset_timeout 1, sticky; branch_stall_disable 1; halted 1; stall_en 1.

Function
REQ-011 SHALL update all state only on clk_en=1 edges, except pending-bit clearing by reset_ack_in (REQ-016), which SHALL occur on every clk edge.
REQ-012 SHALL accept a reset command when clk_en && instruction_valid && minor_opcode_in==RESET_OPCODE && functional_unit_enable[RESET_FUNIT] && state==RUN.
REQ-013 SHALL implement FSM states RUN, ISSUE, WAIT_ACK, HALTED; the reset state is RUN.
REQ-014 RUN->ISSUE on accepted command with nonzero reset_mask_in: pending<=reset_mask_in, reset_req_out<=reset_mask_in, timeout counter<=0, reset_timeout<=0.
REQ-015 Accepted command with reset_mask_in==0 SHALL be a no-op: stay RUN, no pulse, reset_timeout unchanged.
REQ-016 ISSUE SHALL last exactly one clk_en cycle with reset_req_out registered high for that cycle only, then go to WAIT_ACK; reset_ack_in[i]=1 SHALL clear pending[i] in ISSUE or WAIT_ACK; acks for non-pending domains SHALL be ignored.
REQ-017 WAIT_ACK->RUN when pending==0, evaluated on clk_en edges.
REQ-018 In WAIT_ACK the counter SHALL increment per clk_en cycle; on reaching ACK_TIMEOUT with pending!=0: pending<=0, reset_timeout<=1, go RUN.
REQ-019 An ack arriving on the same edge as the timeout SHALL still clear its bit; the timeout fires only if pending remains nonzero after that clear.
REQ-020 reset_busy SHALL be 1 in ISSUE and WAIT_ACK.
REQ-021 RUN->HALTED when halt_req_in=1 and no command is accepted on that edge; the reset command wins on a simultaneous request.
REQ-022 HALTED->RUN on resume_in=1; halt_req_in still high SHALL re-enter HALTED on the next clk_en edge; commands SHALL be ignored in HALTED.
REQ-023 halted SHALL be 1 exactly while state==HALTED.
REQ-024 branch_stall_delay SHALL be a register loaded with instruction_valid && branch_stall_in each clk_en edge; branch_stall_disable = branch_stall_delay.
REQ-025 stall_en SHALL be combinational: (state!=RUN) || branch_stall_delay || |stall_sources_in || halt_req_in.
REQ-026 Commands arriving in ISSUE or WAIT_ACK SHALL be ignored with no state change.

Reset
REQ-027 async_rst_n=0 SHALL immediately force state=RUN, pending=0, counter=0, reset_timeout=0, branch_stall_delay=0, reset_req_out=0, reset_busy=0, halted=0, independent of clk and clk_en.
REQ-028 Assertion mid-ISSUE/WAIT_ACK/HALTED SHALL abort the operation with no further pulses; stall_en then reflects only stall_sources_in and halt_req_in.
REQ-029 Deassertion SHALL be synchronised externally; the first clk_en edge after deassertion SHALL evaluate normally.

Verification
REQ-030 Mask 4'b0101 command, acks for domains 0 and 2 on cycles +3 and +5 -> reset_req_out=0101 for one cycle, reset_busy high until the edge after +5, then RUN.
REQ-031 ACK_TIMEOUT=8, mask 4'b0011, ack for domain 0 only -> reset_timeout=1 after 8 WAIT_ACK clk_en cycles, state RUN, pending=0.
REQ-032 Reset command and halt_req_in both 1 in RUN -> ISSUE taken; HALTED entered after the acks complete.
REQ-033 halt_req_in pulse, then resume_in pulse 4 cycles later -> halted=1 for exactly those cycles, stall_en=1 throughout.
REQ-034 clk_en toggled 0/1 during WAIT_ACK -> counter advances only on clk_en cycles; an ack with clk_en=0 still clears pending.
REQ-035 async_rst_n pulsed low in WAIT_ACK -> all outputs at reset values immediately; no reset_req_out pulse after release.

Source files
------------

// File: rtl/reset_stall_controller.sv
// Reset-command sequencer and pipeline stall generator: issues per-domain reset
// request pulses, tracks their acks with a timeout, and manages halt/resume.
module reset_stall_controller #(
  parameter int         RESET_DOMAINS = 4,
  parameter int         STALL_SOURCES = 3,
  parameter int         FUNIT_COUNT   = 5,
  parameter int         RESET_FUNIT   = 2,
  parameter logic [3:0] RESET_OPCODE  = 4'hE,
  parameter int         ACK_TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     async_rst_n,
  input  logic                     clk_en,
  input  logic                     instruction_valid,
  input  logic [3:0]               minor_opcode_in,
  input  logic [FUNIT_COUNT-1:0]   functional_unit_enable,
  input  logic [RESET_DOMAINS-1:0] reset_mask_in,
  input  logic [RESET_DOMAINS-1:0] reset_ack_in,
  input  logic                     branch_stall_in,
  input  logic [STALL_SOURCES-1:0] stall_sources_in,
  input  logic                     halt_req_in,
  input  logic                     resume_in,
  output logic [RESET_DOMAINS-1:0] reset_req_out,
  output logic                     reset_busy,
  output logic                     reset_timeout,
  output logic                     branch_stall_disable,
  output logic                     halted,
  output logic                     stall_en,
  output logic [1:0]               dbgState,
  output logic [RESET_DOMAINS-1:0] dbgPending
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    HALTED   = 2'd3
  } state_t;

  state_t                   state;
  logic [RESET_DOMAINS-1:0] pending;
  logic [RESET_DOMAINS-1:0] pendingCleared;
  logic [CW-1:0]            counter;
  logic [CW-1:0]            counterNext;
  logic                     branchStallDelay;
  logic                     cmdAccept;
  logic                     ackWindow;
  logic                     unusedFuBits;

  // Command handshake: valid-only, no ready. A command is taken when it is
  // valid on an enabled edge in RUN; in any other state it is silently dropped.
  assign cmdAccept = clk_en && instruction_valid &&
                     (minor_opcode_in == RESET_OPCODE) &&
                     functional_unit_enable[RESET_FUNIT] && (state == RUN);

  assign ackWindow      = (state == ISSUE) || (state == WAIT_ACK);
  assign pendingCleared = pending & ~reset_ack_in;
  assign counterNext    = counter + CW'(1);
  assign unusedFuBits   = ^functional_unit_enable;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state            <= RUN;
      pending          <= '0;
      counter          <= '0;
      reset_timeout    <= 1'b0;
      branchStallDelay <= 1'b0;
      reset_req_out    <= '0;
      reset_busy       <= 1'b0;
      halted           <= 1'b0;
    end else begin
      // Acks are level signals from other clock-enable domains, so they clear
      // pending bits on every edge; everything else waits for clk_en.
      if (ackWindow) pending <= pendingCleared;
      if (clk_en) begin
        branchStallDelay <= instruction_valid && branch_stall_in;
        reset_req_out    <= '0;
        case (state)
          RUN: begin
            if (cmdAccept && (reset_mask_in != '0)) begin
              state         <= ISSUE;
              pending       <= reset_mask_in;
              reset_req_out <= reset_mask_in;
              counter       <= '0;
              reset_timeout <= 1'b0;
              reset_busy    <= 1'b1;
            end else if (halt_req_in && !cmdAccept) begin
              state  <= HALTED;
              halted <= 1'b1;
            end
          end
          ISSUE: state <= WAIT_ACK;
          WAIT_ACK: begin
            if (pendingCleared == '0) begin
              state      <= RUN;
              reset_busy <= 1'b0;
            end else if (counterNext == TIMEOUT_VAL) begin
              pending       <= '0;
              reset_timeout <= 1'b1;
              state         <= RUN;
              reset_busy    <= 1'b0;
            end else begin
              counter <= counterNext;
            end
          end
          HALTED: begin
            if (resume_in) begin
              state  <= RUN;
              halted <= 1'b0;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  assign branch_stall_disable = branchStallDelay;
  assign stall_en   = (state != RUN) || branchStallDelay || (|stall_sources_in) || halt_req_in;
  assign dbgState   = state;
  assign dbgPending = pending;

endmodule

// File: tb/tb_reset_stall_controller.sv
// Directed bench for reset_stall_controller: request pulses are scoreboarded,
// state and status outputs are checked against hand-derived expectations.
module tb_reset_stall_controller;

  logic       clk = 1'b0;
  logic       async_rst_n;
  logic       clk_en;
  logic       instruction_valid;
  logic [3:0] minor_opcode_in;
  logic [4:0] functional_unit_enable;
  logic [3:0] reset_mask_in;
  logic [3:0] reset_ack_in;
  logic       branch_stall_in;
  logic [2:0] stall_sources_in;
  logic       halt_req_in;
  logic       resume_in;
  logic [3:0] reset_req_out;
  logic       reset_busy;
  logic       reset_timeout;
  logic       branch_stall_disable;
  logic       halted;
  logic       stall_en;
  logic [1:0] dbgState;
  logic [3:0] dbgPending;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [3:0] exp_q[$];

  reset_stall_controller #(.ACK_TIMEOUT(8)) dut (
    .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
    .instruction_valid(instruction_valid), .minor_opcode_in(minor_opcode_in),
    .functional_unit_enable(functional_unit_enable), .reset_mask_in(reset_mask_in),
    .reset_ack_in(reset_ack_in), .branch_stall_in(branch_stall_in),
    .stall_sources_in(stall_sources_in), .halt_req_in(halt_req_in), .resume_in(resume_in),
    .reset_req_out(reset_req_out), .reset_busy(reset_busy), .reset_timeout(reset_timeout),
    .branch_stall_disable(branch_stall_disable), .halted(halted), .stall_en(stall_en),
    .dbgState(dbgState), .dbgPending(dbgPending)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    clk_en = 1'b1; instruction_valid = 1'b0; minor_opcode_in = 4'h0;
    functional_unit_enable = 5'b0; reset_mask_in = 4'b0; reset_ack_in = 4'b0;
    branch_stall_in = 1'b0; stall_sources_in = 3'b0; halt_req_in = 1'b0; resume_in = 1'b0;
  endtask

  task automatic drive_cmd(input logic [3:0] mask, input bit expect_pulse);
    instruction_valid = 1'b1; minor_opcode_in = 4'hE;
    functional_unit_enable = 5'b00100; reset_mask_in = mask;
    if (expect_pulse) exp_q.push_back(mask);
  endtask

  // Every nonzero request pulse must match the next expected mask.
  always @(negedge clk) begin
    if (async_rst_n && reset_req_out != 4'b0) begin
      if (exp_q.size() != 0) check_eq("req_pulse", 32'(reset_req_out), 32'(exp_q.pop_front()));
      else check_eq("unexp_pulse", 32'(reset_req_out), 32'(0));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    async_rst_n = 1'b0;
    drive_idle();
    cyc(); cyc();
    check_eq("rst_state", 32'(dbgState), 32'(0));
    check_eq("rst_busy", 32'(reset_busy), 32'(0));
    check_eq("rst_halted", 32'(halted), 32'(0));
    check_eq("rst_timeout", 32'(reset_timeout), 32'(0));
    check_eq("rst_stall", 32'(stall_en), 32'(0));
    async_rst_n = 1'b1;
    cyc();

    // Mask 0101, acks for domains 0 and 2 on cycles +3 and +5
    drive_cmd(4'b0101, 1); cyc();
    check_eq("a_issue_state", 32'(dbgState), 32'(1));
    check_eq("a_issue_busy", 32'(reset_busy), 32'(1));
    drive_idle(); cyc();
    check_eq("a_wait_state", 32'(dbgState), 32'(2));
    check_eq("a_wait_stall", 32'(stall_en), 32'(1));
    reset_ack_in = 4'b1010; cyc();
    check_eq("a_foreign_ack", 32'(dbgPending), 32'(4'b0101));
    reset_ack_in = 4'b0001; cyc();
    check_eq("a_ack0", 32'(dbgPending), 32'(4'b0100));
    reset_ack_in = 4'b0000; cyc();
    check_eq("a_busy_c4", 32'(reset_busy), 32'(1));
    reset_ack_in = 4'b0100; cyc();
    check_eq("a_done_busy", 32'(reset_busy), 32'(0));
    check_eq("a_done_state", 32'(dbgState), 32'(0));
    check_eq("a_no_timeout", 32'(reset_timeout), 32'(0));
    drive_idle();

    // Timeout: mask 0011, only domain 0 acks, 8 WAIT_ACK cycles
    drive_cmd(4'b0011, 1); cyc();
    drive_idle(); cyc();
    reset_ack_in = 4'b0001; cyc();
    check_eq("b_pend", 32'(dbgPending), 32'(4'b0010));
    reset_ack_in = 4'b0000;
    for (int i = 0; i < 6; i++) cyc();
    check_eq("b_wait7_state", 32'(dbgState), 32'(2));
    check_eq("b_wait7_to", 32'(reset_timeout), 32'(0));
    cyc();
    check_eq("b_to_flag", 32'(reset_timeout), 32'(1));
    check_eq("b_to_state", 32'(dbgState), 32'(0));
    check_eq("b_to_pend", 32'(dbgPending), 32'(0));
    check_eq("b_to_busy", 32'(reset_busy), 32'(0));
    cyc();
    check_eq("b_sticky", 32'(reset_timeout), 32'(1));
    drive_cmd(4'b0000, 0); cyc();
    check_eq("b_zero_state", 32'(dbgState), 32'(0));
    check_eq("b_zero_to", 32'(reset_timeout), 32'(1));
    drive_idle();

    // Command and halt together: command wins, halt follows the acks
    drive_cmd(4'b1000, 1); halt_req_in = 1'b1; cyc();
    check_eq("c_issue", 32'(dbgState), 32'(1));
    check_eq("c_to_clear", 32'(reset_timeout), 32'(0));
    drive_idle(); halt_req_in = 1'b1; cyc();
    check_eq("c_wait", 32'(dbgState), 32'(2));
    reset_ack_in = 4'b1000; cyc();
    check_eq("c_run", 32'(dbgState), 32'(0));
    reset_ack_in = 4'b0000; cyc();
    check_eq("c_halted", 32'(halted), 32'(1));
    halt_req_in = 1'b0; resume_in = 1'b1; cyc();
    check_eq("c_resumed", 32'(halted), 32'(0));
    resume_in = 1'b0;

    // Halt pulse, resume 4 cycles later; command ignored while halted
    halt_req_in = 1'b1; cyc();
    halt_req_in = 1'b0;
    check_eq("d_halt0", 32'(halted), 32'(1));
    check_eq("d_stall0", 32'(stall_en), 32'(1));
    for (int i = 1; i < 4; i++) begin
      if (i == 2) drive_cmd(4'b1111, 0);
      cyc();
      drive_idle();
      check_eq("d_halt_n", 32'(halted), 32'(1));
      check_eq("d_stall_n", 32'(stall_en), 32'(1));
    end
    resume_in = 1'b1; cyc();
    resume_in = 1'b0;
    check_eq("d_resume", 32'(halted), 32'(0));
    check_eq("d_resume_stall", 32'(stall_en), 32'(0));
    halt_req_in = 1'b1; cyc();
    resume_in = 1'b1; cyc();
    check_eq("d_reenter_run", 32'(halted), 32'(0));
    resume_in = 1'b0; cyc();
    check_eq("d_reenter_halt", 32'(halted), 32'(1));
    halt_req_in = 1'b0; resume_in = 1'b1; cyc();
    resume_in = 1'b0;
    check_eq("d_final_run", 32'(dbgState), 32'(0));

    // clk_en gating in WAIT_ACK; ack with clk_en low still clears
    drive_cmd(4'b0110, 1); cyc();
    drive_idle(); cyc();
    clk_en = 1'b0; reset_ack_in = 4'b0010; cyc();
    check_eq("e_ack_noen", 32'(dbgPending), 32'(4'b0100));
    check_eq("e_state_noen", 32'(dbgState), 32'(2));
    reset_ack_in = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      clk_en = 1'b0; cyc();
      clk_en = 1'b1;
      if (k == 3) drive_cmd(4'b1111, 0);
      cyc();
      drive_idle();
      if (k == 7) begin
        check_eq("e_wait7_state", 32'(dbgState), 32'(2));
        check_eq("e_wait7_pend", 32'(dbgPending), 32'(4'b0100));
      end
    end
    check_eq("e_to_state", 32'(dbgState), 32'(0));
    check_eq("e_to_flag", 32'(reset_timeout), 32'(1));

    // Branch-stall delay register and combinational stall terms
    instruction_valid = 1'b1; branch_stall_in = 1'b1; cyc();
    check_eq("f_bsd_set", 32'(branch_stall_disable), 32'(1));
    drive_idle(); #1;
    check_eq("f_stall_bsd", 32'(stall_en), 32'(1));
    cyc();
    check_eq("f_bsd_clr", 32'(branch_stall_disable), 32'(0));
    branch_stall_in = 1'b1; cyc();
    check_eq("f_bsd_noiv", 32'(branch_stall_disable), 32'(0));
    instruction_valid = 1'b1; clk_en = 1'b0; cyc();
    check_eq("f_bsd_noen", 32'(branch_stall_disable), 32'(0));
    drive_idle();
    stall_sources_in = 3'b100; #1;
    check_eq("f_stall_src", 32'(stall_en), 32'(1));
    stall_sources_in = 3'b000; halt_req_in = 1'b1; #1;
    check_eq("f_stall_halt", 32'(stall_en), 32'(1));
    halt_req_in = 1'b0; #1;
    check_eq("f_stall_none", 32'(stall_en), 32'(0));
    drive_cmd(4'b1111, 0); functional_unit_enable = 5'b11011; cyc();
    check_eq("f_wrong_fu", 32'(dbgState), 32'(0));
    drive_cmd(4'b1111, 0); minor_opcode_in = 4'hD; cyc();
    check_eq("f_wrong_op", 32'(dbgState), 32'(0));
    drive_idle();

    // Asynchronous reset in WAIT_ACK
    drive_cmd(4'b0001, 1); cyc();
    drive_idle(); cyc();
    stall_sources_in = 3'b001;
    #2 async_rst_n = 1'b0;
    #1;
    check_eq("g_state", 32'(dbgState), 32'(0));
    check_eq("g_busy", 32'(reset_busy), 32'(0));
    check_eq("g_pend", 32'(dbgPending), 32'(0));
    check_eq("g_timeout", 32'(reset_timeout), 32'(0));
    check_eq("g_req", 32'(reset_req_out), 32'(0));
    check_eq("g_stall_src", 32'(stall_en), 32'(1));
    stall_sources_in = 3'b000; #1;
    check_eq("g_stall_idle", 32'(stall_en), 32'(0));
    cyc(); cyc();
    async_rst_n = 1'b1;
    cyc(); cyc();
    drive_cmd(4'b0100, 1); cyc();
    check_eq("g_first_cmd", 32'(dbgState), 32'(1));
    drive_idle(); cyc();
    reset_ack_in = 4'b0100; cyc();
    check_eq("g_cmd_done", 32'(dbgState), 32'(0));
    drive_idle();

    // Asynchronous reset while halted
    halt_req_in = 1'b1; cyc();
    check_eq("h_halted", 32'(halted), 32'(1));
    halt_req_in = 1'b0; async_rst_n = 1'b0; #1;
    check_eq("h_rst_halted", 32'(halted), 32'(0));
    check_eq("h_rst_stall", 32'(stall_en), 32'(0));
    cyc();
    async_rst_n = 1'b1;
    cyc(); cyc();
    check_eq("h_after_state", 32'(dbgState), 32'(0));

    check_eq("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
